// File: rtl/p03_clock_pkg.sv
// Shared constants, digit widths and the 24h->12h display helper for the
// VGA clock time-of-day engine.
package p03_clock_pkg;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HRS_MAX = 23;

  localparam int SEC_D_W = 3;
  localparam int MIN_D_W = 3;
  localparam int HRS_D_W = 2;
  localparam int U_W     = 4;

  typedef struct packed {
    logic [HRS_D_W-1:0] hrs_d;
    logic [U_W-1:0]     hrs_u;
    logic [MIN_D_W-1:0] min_d;
    logic [U_W-1:0]     min_u;
    logic [SEC_D_W-1:0] sec_d;
    logic [U_W-1:0]     sec_u;
  } time_t;

  // Returns {tens, units} of the 12-hour form of a valid 24-hour BCD hour.
  function automatic logic [HRS_D_W+U_W-1:0] to_12h(input logic [HRS_D_W-1:0] d,
                                                     input logic [U_W-1:0]     u);
    logic [4:0] h;
    logic [4:0] c;
    h = 5'(d) * 5'd10 + 5'(u);
    if (h == 5'd0)       c = 5'd12;
    else if (h > 5'd12)  c = h - 5'd12;
    else                 c = h;
    if (c >= 5'd10) return {2'd1, 4'(c - 5'd10)};
    else            return {2'd0, c[3:0]};
  endfunction

endpackage

// File: rtl/p03_timekeeper_if.sv
// Control inputs and display outputs of the time-of-day engine; the engine
// takes the slave side, the button/renderer glue the master side.
interface p03_timekeeper_if;
  import p03_clock_pkg::*;

  logic               run;
  logic               mode_12h;
  logic               adj_sec;
  logic               adj_min;
  logic               adj_hrs;
  logic               alarm_en;
  logic [HRS_D_W-1:0] alarm_hrs_d;
  logic [U_W-1:0]     alarm_hrs_u;
  logic [MIN_D_W-1:0] alarm_min_d;
  logic [U_W-1:0]     alarm_min_u;

  logic [HRS_D_W-1:0] hrs_d;
  logic [U_W-1:0]     hrs_u;
  logic [MIN_D_W-1:0] min_d;
  logic [U_W-1:0]     min_u;
  logic [SEC_D_W-1:0] sec_d;
  logic [U_W-1:0]     sec_u;
  logic               pm;
  logic               sec_tick;
  logic               min_tick;
  logic [3:0]         color_offset;
  logic               alarm_hit;

  modport master (
    output run, mode_12h, adj_sec, adj_min, adj_hrs, alarm_en,
           alarm_hrs_d, alarm_hrs_u, alarm_min_d, alarm_min_u,
    input  hrs_d, hrs_u, min_d, min_u, sec_d, sec_u, pm,
           sec_tick, min_tick, color_offset, alarm_hit
  );

  modport slave (
    input  run, mode_12h, adj_sec, adj_min, adj_hrs, alarm_en,
           alarm_hrs_d, alarm_hrs_u, alarm_min_d, alarm_min_u,
    output hrs_d, hrs_u, min_d, min_u, sec_d, sec_u, pm,
           sec_tick, min_tick, color_offset, alarm_hit
  );

endinterface

// File: rtl/p03_bcd_mod_counter.sv
// Two-digit BCD counter that counts 00..MAX_D:MAX_U and wraps to 00;
// wrap flags the increment that rolls over so the caller can carry.
module p03_bcd_mod_counter #(
  parameter int D_W   = 3,
  parameter int MAX_D = 5,
  parameter int MAX_U = 9
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           inc,
  output logic [D_W-1:0] d,
  output logic [3:0]     u,
  output logic           wrap
);

  logic [D_W-1:0] d_q, d_d;
  logic [3:0]     u_q, u_d;
  logic           at_max;

  always_comb begin
    at_max = (d_q == D_W'(MAX_D)) && (u_q == 4'(MAX_U));
    wrap   = inc && at_max;
    d_d    = d_q;
    u_d    = u_q;
    if (inc) begin
      if (at_max) begin
        d_d = '0;
        u_d = '0;
      end else if (u_q == 4'd9) begin
        d_d = d_q + D_W'(1);
        u_d = '0;
      end else begin
        u_d = u_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      d_q <= '0;
      u_q <= '0;
    end else begin
      d_q <= d_d;
      u_q <= u_d;
    end
  end

  assign d = d_q;
  assign u = u_q;

endmodule

// File: rtl/p03_timekeeper.sv
// BCD time-of-day engine: tick prescaler, single-cycle carry ripple,
// per-field adjust, 12/24h display, minute colour offset and alarm.
module p03_timekeeper
  import p03_clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 31_500_000,
  parameter int CNT_W         = 25
) (
  input  logic              clk,
  input  logic              reset,
  p03_timekeeper_if.slave   bus
);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pre_wrap;
  logic               acc_min, acc_hrs, acc_tick;
  logic               sec_inc, min_inc, hrs_inc;
  logic               sec_wrap, min_wrap, day_rollover_unused;
  logic [SEC_D_W-1:0] sec_d_i;
  logic [MIN_D_W-1:0] min_d_i;
  logic [HRS_D_W-1:0] hrs_d_i;
  logic [U_W-1:0]     sec_u_i, min_u_i, hrs_u_i;

  logic               sec_evt_q, sec_evt_d;
  logic               min_evt_q, min_evt_d;
  time_t              disp_q, disp_d;
  logic               pm_q, pm_d;
  logic               sec_tick_q, sec_tick_d;
  logic               min_tick_q, min_tick_d;
  logic [3:0]         color_q, color_d;
  logic               alarm_q, alarm_d;
  logic [5:0]         hrs_disp;
  logic               alarm_match;

  // A tick loses to any adjust in the same cycle, but the prescaler still wraps.
  always_comb begin
    pre_wrap = bus.run && (cnt_q == CNT_W'(TICKS_PER_SEC - 1));
    acc_min  = !bus.adj_sec && bus.adj_min;
    acc_hrs  = !bus.adj_sec && !bus.adj_min && bus.adj_hrs;
    acc_tick = pre_wrap && !(bus.adj_sec || bus.adj_min || bus.adj_hrs);
    cnt_d    = cnt_q;
    if (bus.adj_sec)  cnt_d = '0;
    else if (pre_wrap) cnt_d = '0;
    else if (bus.run) cnt_d = cnt_q + CNT_W'(1);
  end

  assign sec_inc = bus.adj_sec || acc_tick;
  assign min_inc = acc_min || (acc_tick && sec_wrap);
  assign hrs_inc = acc_hrs || (acc_tick && sec_wrap && min_wrap);

  p03_bcd_mod_counter #(.D_W(SEC_D_W), .MAX_D(SEC_MAX / 10), .MAX_U(SEC_MAX % 10)) u_sec (
    .clk(clk), .clr(reset), .inc(sec_inc), .d(sec_d_i), .u(sec_u_i), .wrap(sec_wrap)
  );

  p03_bcd_mod_counter #(.D_W(MIN_D_W), .MAX_D(MIN_MAX / 10), .MAX_U(MIN_MAX % 10)) u_min (
    .clk(clk), .clr(reset), .inc(min_inc), .d(min_d_i), .u(min_u_i), .wrap(min_wrap)
  );

  p03_bcd_mod_counter #(.D_W(HRS_D_W), .MAX_D(HRS_MAX / 10), .MAX_U(HRS_MAX % 10)) u_hrs (
    .clk(clk), .clr(reset), .inc(hrs_inc), .d(hrs_d_i), .u(hrs_u_i), .wrap(day_rollover_unused)
  );

  // Event flags ride one cycle behind the state so the pulses meet the new time at the outputs.
  always_comb begin
    sec_evt_d    = acc_tick;
    min_evt_d    = min_inc;
    hrs_disp     = bus.mode_12h ? to_12h(hrs_d_i, hrs_u_i) : {hrs_d_i, hrs_u_i};
    disp_d.hrs_d = hrs_disp[5:4];
    disp_d.hrs_u = hrs_disp[3:0];
    disp_d.min_d = min_d_i;
    disp_d.min_u = min_u_i;
    disp_d.sec_d = sec_d_i;
    disp_d.sec_u = sec_u_i;
    pm_d         = (hrs_d_i == 2'd2) || ((hrs_d_i == 2'd1) && (hrs_u_i >= 4'd2));
    sec_tick_d   = sec_evt_q;
    min_tick_d   = min_evt_q;
    color_d      = color_q + {3'b000, min_evt_q};
    alarm_match  = (hrs_d_i == bus.alarm_hrs_d) && (hrs_u_i == bus.alarm_hrs_u) &&
                   (min_d_i == bus.alarm_min_d) && (min_u_i == bus.alarm_min_u) &&
                   (sec_d_i == '0) && (sec_u_i == '0);
    alarm_d      = sec_evt_q && bus.alarm_en && alarm_match;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      sec_evt_q  <= 1'b0;
      min_evt_q  <= 1'b0;
      disp_q     <= '0;
      pm_q       <= 1'b0;
      sec_tick_q <= 1'b0;
      min_tick_q <= 1'b0;
      color_q    <= '0;
      alarm_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sec_evt_q  <= sec_evt_d;
      min_evt_q  <= min_evt_d;
      disp_q     <= disp_d;
      pm_q       <= pm_d;
      sec_tick_q <= sec_tick_d;
      min_tick_q <= min_tick_d;
      color_q    <= color_d;
      alarm_q    <= alarm_d;
    end
  end

  assign bus.hrs_d        = disp_q.hrs_d;
  assign bus.hrs_u        = disp_q.hrs_u;
  assign bus.min_d        = disp_q.min_d;
  assign bus.min_u        = disp_q.min_u;
  assign bus.sec_d        = disp_q.sec_d;
  assign bus.sec_u        = disp_q.sec_u;
  assign bus.pm           = pm_q;
  assign bus.sec_tick     = sec_tick_q;
  assign bus.min_tick     = min_tick_q;
  assign bus.color_offset = color_q;
  assign bus.alarm_hit    = alarm_q;

endmodule

// File: tb/tb_p03_timekeeper.sv
// Bench for p03_timekeeper: directed scenarios then random traffic, every
// cycle compared against a seconds-of-day reference model.
module tb_p03_timekeeper;

  localparam int TPS = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  p03_timekeeper_if bus ();

  p03_timekeeper #(.TICKS_PER_SEC(TPS), .CNT_W(3)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;
  int hit_count = 0;

  // Reference model: time as seconds of day, prescaler as plain count.
  int m_t = 0, m_pre = 0;
  bit m_sec_evt = 0, m_min_evt = 0;
  int e_h = 0, e_m = 0, e_s = 0, e_pm = 0, e_st = 0, e_mt = 0, e_col = 0, e_al = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int alarm_secs();
    int ah, am;
    if (bus.alarm_hrs_u > 9 || bus.alarm_min_u > 9) return -1;
    ah = int'(bus.alarm_hrs_d) * 10 + int'(bus.alarm_hrs_u);
    am = int'(bus.alarm_min_d) * 10 + int'(bus.alarm_min_u);
    if (ah > 23 || am > 59) return -1;
    return ah * 3600 + am * 60;
  endfunction

  task automatic model_edge();
    int h, mm;
    bit cand;
    if (reset) begin
      m_t = 0; m_pre = 0; m_sec_evt = 0; m_min_evt = 0;
      e_h = 0; e_m = 0; e_s = 0; e_pm = 0; e_st = 0; e_mt = 0; e_col = 0; e_al = 0;
    end else begin
      h    = m_t / 3600;
      e_h  = bus.mode_12h ? ((h == 0) ? 12 : ((h > 12) ? h - 12 : h)) : h;
      e_m  = (m_t / 60) % 60;
      e_s  = m_t % 60;
      e_pm = (h >= 12);
      e_st = m_sec_evt;
      e_mt = m_min_evt;
      e_col = (e_col + int'(m_min_evt)) % 16;
      e_al = (m_sec_evt && bus.alarm_en && (alarm_secs() == m_t)) ? 1 : 0;
      m_sec_evt = 0;
      m_min_evt = 0;
      cand = bus.run && (m_pre == TPS - 1);
      if (bus.run) m_pre = (m_pre + 1) % TPS;
      mm = (m_t / 60) % 60;
      if (bus.adj_sec) begin
        m_pre = 0;
        m_t = m_t - (m_t % 60) + ((m_t % 60) + 1) % 60;
      end else if (bus.adj_min) begin
        m_t = m_t + (((mm + 1) % 60) - mm) * 60;
        m_min_evt = 1;
      end else if (bus.adj_hrs) begin
        m_t = m_t + (((h + 1) % 24) - h) * 3600;
      end else if (cand) begin
        m_t = (m_t + 1) % 86400;
        m_sec_evt = 1;
        m_min_evt = (m_t % 60 == 0);
      end
    end
  endtask

  task automatic check_all();
    chk("hrs_d", 32'(bus.hrs_d), e_h / 10);
    chk("hrs_u", 32'(bus.hrs_u), e_h % 10);
    chk("min_d", 32'(bus.min_d), e_m / 10);
    chk("min_u", 32'(bus.min_u), e_m % 10);
    chk("sec_d", 32'(bus.sec_d), e_s / 10);
    chk("sec_u", 32'(bus.sec_u), e_s % 10);
    chk("pm", 32'(bus.pm), e_pm);
    chk("sec_tick", 32'(bus.sec_tick), e_st);
    chk("min_tick", 32'(bus.min_tick), e_mt);
    chk("color_offset", 32'(bus.color_offset), e_col);
    chk("alarm_hit", 32'(bus.alarm_hit), e_al);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    if (bus.alarm_hit === 1'b1) hit_count++;
    check_all();
  endtask

  task automatic set_time(input int h, input int m, input int s);
    int nh, nm, ns;
    nh = (h - m_t / 3600 + 24) % 24;
    nm = (m - (m_t / 60) % 60 + 60) % 60;
    ns = (s - m_t % 60 + 60) % 60;
    bus.adj_hrs = 1'b1;
    for (int i = 0; i < nh; i++) cyc();
    bus.adj_hrs = 1'b0;
    bus.adj_min = 1'b1;
    for (int i = 0; i < nm; i++) cyc();
    bus.adj_min = 1'b0;
    bus.adj_sec = 1'b1;
    for (int i = 0; i < ns; i++) cyc();
    bus.adj_sec = 1'b0;
    cyc();
  endtask

  task automatic show_hours(input string tag, input bit mode, input int d, input int u, input int pm);
    bus.mode_12h = mode;
    cyc();
    chk({tag, "_hrs_d"}, 32'(bus.hrs_d), d);
    chk({tag, "_hrs_u"}, 32'(bus.hrs_u), u);
    chk({tag, "_pm"}, 32'(bus.pm), pm);
  endtask

  initial begin
    int ticks, n, first, col0, mm0, ss0, hits0;
    bit hit_ok;
    reset = 1'b1;
    bus.run = 1'b0; bus.mode_12h = 1'b0;
    bus.adj_sec = 1'b0; bus.adj_min = 1'b0; bus.adj_hrs = 1'b0;
    bus.alarm_en = 1'b0;
    bus.alarm_hrs_d = 2'd0; bus.alarm_hrs_u = 4'd0;
    bus.alarm_min_d = 3'd0; bus.alarm_min_u = 4'd0;
    repeat (3) cyc();

    // 1: free run from reset
    reset = 1'b0;
    bus.run = 1'b1;
    ticks = 0; first = 0; n = 0;
    while (ticks < 40 && n < 400) begin
      cyc();
      n++;
      if (bus.sec_tick === 1'b1) begin
        ticks++;
        if (ticks == 1) begin
          first = n;
          chk("s1_first_sec_u", 32'(bus.sec_u), 1);
        end
      end
    end
    chk("s1_first_tick_cycle", first, TPS + 1);
    chk("s1_ticks", ticks, 40);
    chk("s1_sec_d", 32'(bus.sec_d), 4);
    chk("s1_sec_u", 32'(bus.sec_u), 0);

    // 2: full ripple 23:59:59 -> 00:00:00
    bus.run = 1'b0;
    set_time(23, 59, 59);
    col0 = e_col;
    bus.run = 1'b1;
    n = 0;
    do begin cyc(); n++; end while (bus.sec_tick !== 1'b1 && n < 10);
    chk("s2_tick_seen", 32'(bus.sec_tick), 1);
    chk("s2_time", {26'd0, bus.hrs_d, bus.hrs_u, bus.min_d, bus.min_u, bus.sec_d, bus.sec_u} == 0, 1);
    chk("s2_min_tick", 32'(bus.min_tick), 1);
    chk("s2_color", 32'(bus.color_offset), (col0 + 1) % 16);

    // 3: adj_sec clears the prescaler
    bus.run = 1'b0;
    set_time(m_t / 3600, 5, 59);
    bus.run = 1'b1;
    bus.adj_sec = 1'b1;
    cyc();
    bus.adj_sec = 1'b0;
    n = 0;
    do begin
      cyc(); n++;
      if (n == 1) begin
        chk("s3_sec_zero", 32'(bus.sec_d) * 10 + 32'(bus.sec_u), 0);
        chk("s3_min_kept", 32'(bus.min_d) * 10 + 32'(bus.min_u), 5);
      end
    end while (bus.sec_tick !== 1'b1 && n < 12);
    chk("s3_tick_latency", n, TPS + 1);

    // 4: 12h display at 00, 12, 13
    bus.run = 1'b0;
    set_time(0, 7, 0);
    show_hours("s4_00_12h", 1'b1, 1, 2, 0);
    show_hours("s4_00_24h", 1'b0, 0, 0, 0);
    set_time(12, 7, 0);
    show_hours("s4_12_12h", 1'b1, 1, 2, 1);
    show_hours("s4_12_24h", 1'b0, 1, 2, 1);
    set_time(13, 7, 0);
    show_hours("s4_13_12h", 1'b1, 0, 1, 1);
    show_hours("s4_13_24h", 1'b0, 1, 3, 1);

    // 5: alarm 07:30 from a tick only
    bus.alarm_hrs_d = 2'd0; bus.alarm_hrs_u = 4'd7;
    bus.alarm_min_d = 3'd3; bus.alarm_min_u = 4'd0;
    bus.alarm_en = 1'b1;
    set_time(7, 29, 59);
    hits0 = hit_count;
    hit_ok = 1'b0;
    bus.run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (bus.alarm_hit === 1'b1)
        hit_ok = (bus.hrs_u == 4'd7) && (bus.min_d == 3'd3) && (bus.min_u == 4'd0) &&
                 (bus.sec_d == 3'd0) && (bus.sec_u == 4'd0);
    end
    chk("s5_hits_tick", hit_count - hits0, 1);
    chk("s5_hit_time", 32'(hit_ok), 1);
    bus.run = 1'b0;
    set_time(7, 29, 0);
    hits0 = hit_count;
    bus.adj_min = 1'b1;
    cyc();
    bus.adj_min = 1'b0;
    repeat (4) cyc();
    chk("s5_adj_min_at_alarm", 32'(bus.min_d) * 10 + 32'(bus.min_u), 30);
    chk("s5_hits_adjust", hit_count - hits0, 0);
    bus.alarm_en = 1'b0;

    // 6: adj_min colliding with a tick, then reset mid-prescale
    bus.run = 1'b1;
    n = 0;
    do begin cyc(); n++; end while (m_pre != TPS - 1 && n < 10);
    mm0 = (m_t / 60) % 60;
    ss0 = m_t % 60;
    bus.adj_min = 1'b1;
    cyc();
    bus.adj_min = 1'b0;
    cyc();
    chk("s6_no_sec_tick", 32'(bus.sec_tick), 0);
    chk("s6_min_tick", 32'(bus.min_tick), 1);
    chk("s6_sec_same", 32'(bus.sec_d) * 10 + 32'(bus.sec_u), ss0);
    chk("s6_min_inc", 32'(bus.min_d) * 10 + 32'(bus.min_u), (mm0 + 1) % 60);
    n = 0;
    do begin cyc(); n++; end while (m_pre != 2 && n < 10);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("s6_reset_time", {26'd0, bus.hrs_d, bus.hrs_u, bus.min_d, bus.min_u, bus.sec_d, bus.sec_u} == 0, 1);
    chk("s6_reset_color", 32'(bus.color_offset), 0);
    chk("s6_reset_pulses", {29'd0, bus.sec_tick, bus.min_tick, bus.alarm_hit}, 0);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      reset       = ($urandom_range(0, 199) == 0);
      bus.run     = ($urandom_range(0, 9) != 0);
      bus.adj_sec = ($urandom_range(0, 11) == 0);
      bus.adj_min = ($urandom_range(0, 11) == 0);
      bus.adj_hrs = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 49) == 0) bus.mode_12h = ~bus.mode_12h;
      if ($urandom_range(0, 99) == 0) bus.alarm_en = ~bus.alarm_en;
      if ($urandom_range(0, 99) == 0) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.alarm_hrs_d = 2'($urandom_range(0, 3));
          bus.alarm_hrs_u = 4'($urandom_range(0, 15));
          bus.alarm_min_d = 3'($urandom_range(0, 7));
          bus.alarm_min_u = 4'($urandom_range(0, 15));
        end else begin
          n = (m_t / 60 + 1) % 1440;
          bus.alarm_hrs_d = 2'((n / 60) / 10);
          bus.alarm_hrs_u = 4'((n / 60) % 10);
          bus.alarm_min_d = 3'((n % 60) / 10);
          bus.alarm_min_u = 4'((n % 60) % 10);
        end
      end
      cyc();
    end
    reset = 1'b0;
    bus.adj_sec = 1'b0; bus.adj_min = 1'b0; bus.adj_hrs = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
